// File: rtl/ps2_key_event_queue_if.sv
// Bus bundle between the PS/2 byte source, the key event queue and its consumer.
// evt_ascii exists only when KEY_ASCII_EN is defined.
interface ps2_key_event_queue_if #(
  parameter int unsigned CNT_W = 8
);
  logic [7:0]       ps2_data;
  logic             ps2_ready;
  logic             ps2_overflow;
  logic             nextdata_n;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             key_down;
  logic [CNT_W-1:0] release_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             src_ovf;
`ifdef KEY_ASCII_EN
  logic [7:0]       evt_ascii;

  modport master (
    output ps2_data, ps2_ready, ps2_overflow, evt_ready,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    input  key_down, release_cnt, drop_cnt, src_ovf, evt_ascii
  );
  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow, evt_ready,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    output key_down, release_cnt, drop_cnt, src_ovf, evt_ascii
  );
`else
  modport master (
    output ps2_data, ps2_ready, ps2_overflow, evt_ready,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    input  key_down, release_cnt, drop_cnt, src_ovf
  );
  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow, evt_ready,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    output key_down, release_cnt, drop_cnt, src_ovf
  );
`endif
endinterface

// File: rtl/ps2_key_event_queue.sv
// Pops PS/2 set-2 bytes, folds E0/F0 prefixes into key events and queues them for a consumer.
// Optional KEY_ASCII_EN adds a combinational ASCII view of the head event.
module ps2_key_event_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rest,
  ps2_key_event_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  localparam logic [7:0] B_EXT = 8'hE0;
  localparam logic [7:0] B_BRK = 8'hF0;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  logic             r_nextdata_n;
  logic [7:0]       r_byte;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_emit;
  evt_t             w_evt;

  evt_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_valid;
  evt_t             r_head;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [OCC_W-1:0] w_count_nxt;
  evt_t             w_head_nxt;

  logic             r_key_down;
  logic [CNT_W-1:0] r_release_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_src_ovf;

  // Byte pop: nextdata_n is the one-cycle pop strobe and doubles as "byte held in r_byte".
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_nextdata_n <= 1'b1;
      r_byte       <= 8'h00;
    end else if (r_nextdata_n && bus.ps2_ready) begin
      r_nextdata_n <= 1'b0;
      r_byte       <= bus.ps2_data;
    end else begin
      r_nextdata_n <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Prefix parser; acts only in the cycle after a pop.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_evt       = '0;
    if (!r_nextdata_n) begin
      case (r_state)
        S_IDLE: begin
          if (r_byte == B_EXT) begin
            w_state_nxt = S_EXT;
          end else if (r_byte == B_BRK) begin
            w_state_nxt = S_BRK;
          end else if (!(r_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1})) begin
            w_emit = 1'b1;
            w_evt  = '{brk: 1'b0, ext: 1'b0, code: r_byte};
          end
        end
        S_EXT: begin
          if (r_byte == B_BRK) begin
            w_state_nxt = S_EXT_BRK;
          end else if (r_byte != B_EXT) begin
            w_state_nxt = S_IDLE;
            w_emit      = 1'b1;
            w_evt       = '{brk: 1'b0, ext: 1'b1, code: r_byte};
          end
        end
        S_BRK, S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          if (r_byte != B_EXT && r_byte != B_BRK) begin
            w_emit = 1'b1;
            w_evt  = '{brk: 1'b1, ext: (r_state == S_EXT_BRK), code: r_byte};
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FIFO control; the head is registered so it holds its last value while empty.
  always_comb begin
    w_full      = (r_count == OCC_W'(DEPTH));
    w_pop       = r_valid & bus.evt_ready;
    w_push      = w_emit & (~w_full | w_pop);
    w_drop      = w_emit & w_full & ~w_pop;
    w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_count_nxt = r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    w_head_nxt  = r_head;
    if (w_count_nxt != '0) begin
      if (w_push && (w_rd_nxt == r_wr_ptr)) w_head_nxt = w_evt;
      else                                  w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  // Status: key state and release count follow every emit, even a dropped one.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_key_down    <= 1'b0;
      r_release_cnt <= '0;
      r_drop_cnt    <= '0;
      r_src_ovf     <= 1'b0;
    end else begin
      r_src_ovf <= r_src_ovf | bus.ps2_overflow;
      if (w_emit) begin
        r_key_down <= ~w_evt.brk;
        if (w_evt.brk) r_release_cnt <= r_release_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bus.nextdata_n  = r_nextdata_n;
  assign bus.evt_valid   = r_valid;
  assign bus.evt_code    = r_head.code;
  assign bus.evt_ext     = r_head.ext;
  assign bus.evt_break   = r_head.brk;
  assign bus.key_down    = r_key_down;
  assign bus.release_cnt = r_release_cnt;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.src_ovf     = r_src_ovf;

`ifdef KEY_ASCII_EN
  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    case (c)
      8'h1C: ascii_of = 8'h41;  8'h32: ascii_of = 8'h42;  8'h21: ascii_of = 8'h43;
      8'h23: ascii_of = 8'h44;  8'h24: ascii_of = 8'h45;  8'h2B: ascii_of = 8'h46;
      8'h34: ascii_of = 8'h47;  8'h33: ascii_of = 8'h48;  8'h43: ascii_of = 8'h49;
      8'h3B: ascii_of = 8'h4A;  8'h42: ascii_of = 8'h4B;  8'h4B: ascii_of = 8'h4C;
      8'h3A: ascii_of = 8'h4D;  8'h31: ascii_of = 8'h4E;  8'h44: ascii_of = 8'h4F;
      8'h4D: ascii_of = 8'h50;  8'h15: ascii_of = 8'h51;  8'h2D: ascii_of = 8'h52;
      8'h1B: ascii_of = 8'h53;  8'h2C: ascii_of = 8'h54;  8'h3C: ascii_of = 8'h55;
      8'h2A: ascii_of = 8'h56;  8'h1D: ascii_of = 8'h57;  8'h22: ascii_of = 8'h58;
      8'h35: ascii_of = 8'h59;  8'h1A: ascii_of = 8'h5A;
      8'h45: ascii_of = 8'h30;  8'h16: ascii_of = 8'h31;  8'h1E: ascii_of = 8'h32;
      8'h26: ascii_of = 8'h33;  8'h25: ascii_of = 8'h34;  8'h2E: ascii_of = 8'h35;
      8'h36: ascii_of = 8'h36;  8'h3D: ascii_of = 8'h37;  8'h3E: ascii_of = 8'h38;
      8'h46: ascii_of = 8'h39;  8'h29: ascii_of = 8'h20;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  assign bus.evt_ascii = (r_valid && !r_head.ext) ? ascii_of(r_head.code) : 8'h00;
`endif

endmodule
